// File: rtl/animated_sprite.sv
// Multi-frame, integer-scaled, palette-indexed sprite renderer with transparency key.
// Optional horizontal mirroring is compiled in with `define SPRITE_HFLIP_EN.
module animated_sprite #(
   parameter int unsigned WIDTH             = 64,
   parameter int unsigned HEIGHT            = 64,
   parameter int unsigned FRAMES            = 4,
   parameter int unsigned SCALE_LOG2        = 1,
   parameter int unsigned FRAME_HOLD        = 8,
   parameter int unsigned TRANSPARENT_INDEX = 0,
   parameter string       IMAGE_FILE        = "image.mem",
   parameter string       PALETTE_FILE      = "palette.mem",
   localparam int unsigned FRAME_W = (FRAMES > 1) ? $clog2(FRAMES) : 1
) (
   input  logic               pixel_clk_in,
   input  logic               rst_n_in,
   input  logic [10:0]        x_in,
   input  logic [9:0]         y_in,
   input  logic [10:0]        hcount_in,
   input  logic [9:0]         vcount_in,
   input  logic               new_frame_in,
   input  logic               anim_en_in,
`ifdef SPRITE_HFLIP_EN
   input  logic               hflip_in,
`endif
   output logic [7:0]         red_out,
   output logic [7:0]         green_out,
   output logic [7:0]         blue_out,
   output logic               opaque_out,
   output logic [FRAME_W-1:0] frame_idx_out
);

   localparam int unsigned DEPTH  = FRAMES * WIDTH * HEIGHT;
   localparam int unsigned ADDR_W = $clog2(DEPTH);
   localparam int unsigned HOLD_W = (FRAME_HOLD > 1) ? $clog2(FRAME_HOLD) : 1;
   localparam int unsigned DX_W   = $clog2(WIDTH);
   localparam int unsigned DY_W   = $clog2(HEIGHT);
   localparam int unsigned SPAN_X = WIDTH << SCALE_LOG2;
   localparam int unsigned SPAN_Y = HEIGHT << SCALE_LOG2;

   logic [7:0]  image_mem   [DEPTH];
   logic [23:0] palette_mem [256];

   logic [10:0]        x_q;
   logic [9:0]         y_q;
   logic [HOLD_W-1:0]  hold_q;
   logic [FRAME_W-1:0] frame_q;
`ifdef SPRITE_HFLIP_EN
   logic               hflip_q;
`endif

   // Position, mirror and animation state only move on the frame pulse so nothing tears mid-frame.
   always_ff @(posedge pixel_clk_in) begin
      if (!rst_n_in) begin
         x_q     <= '0;
         y_q     <= '0;
         hold_q  <= '0;
         frame_q <= '0;
`ifdef SPRITE_HFLIP_EN
         hflip_q <= 1'b0;
`endif
      end else if (new_frame_in) begin
         x_q <= x_in;
         y_q <= y_in;
`ifdef SPRITE_HFLIP_EN
         hflip_q <= hflip_in;
`endif
         if (anim_en_in) begin
            if (hold_q == HOLD_W'(FRAME_HOLD - 1)) begin
               hold_q  <= '0;
               frame_q <= (frame_q == FRAME_W'(FRAMES - 1)) ? '0 : frame_q + FRAME_W'(1);
            end else begin
               hold_q <= hold_q + HOLD_W'(1);
            end
         end
      end
   end

   logic [11:0]       x_end;
   logic [10:0]       y_end;
   logic              in_x_c, in_y_c, in_sprite_c;
   logic [10:0]       dxs_c;
   logic [9:0]        dys_c;
   logic [DX_W-1:0]   dx_c, dx_eff_c;
   logic [DY_W-1:0]   dy_c;
   logic [ADDR_W-1:0] addr_c;

   // Stage 0: widened compares keep a sprite at the right/bottom edge from wrapping to 0.
   always_comb begin
      x_end       = {1'b0, x_q} + 12'(SPAN_X);
      y_end       = {1'b0, y_q} + 11'(SPAN_Y);
      in_x_c      = ({1'b0, hcount_in} >= {1'b0, x_q}) && ({1'b0, hcount_in} < x_end);
      in_y_c      = ({1'b0, vcount_in} >= {1'b0, y_q}) && ({1'b0, vcount_in} < y_end);
      in_sprite_c = in_x_c && in_y_c;
      dxs_c       = hcount_in - x_q;
      dys_c       = vcount_in - y_q;
      dx_c        = DX_W'(dxs_c >> SCALE_LOG2);
      dy_c        = DY_W'(dys_c >> SCALE_LOG2);
`ifdef SPRITE_HFLIP_EN
      dx_eff_c    = hflip_q ? (DX_W'(WIDTH - 1) - dx_c) : dx_c;
`else
      dx_eff_c    = dx_c;
`endif
      addr_c      = ADDR_W'(frame_q) * ADDR_W'(WIDTH * HEIGHT)
                  + ADDR_W'(dy_c) * ADDR_W'(WIDTH)
                  + ADDR_W'(dx_eff_c);
   end

   logic [7:0]  img_rd, idx_q, idx_d;
   logic [23:0] pal_rd;
   logic        in_s1, in_s2, in_s3;
   logic        opaque_c;

   assign opaque_c = in_s3 && (idx_d != 8'(TRANSPARENT_INDEX));

   // Image read + output reg, palette read + gated output reg: four stages end to end.
   always_ff @(posedge pixel_clk_in) begin
      if (!rst_n_in) begin
         img_rd     <= '0;
         idx_q      <= '0;
         idx_d      <= '0;
         pal_rd     <= '0;
         in_s1      <= 1'b0;
         in_s2      <= 1'b0;
         in_s3      <= 1'b0;
         opaque_out <= 1'b0;
         red_out    <= '0;
         green_out  <= '0;
         blue_out   <= '0;
      end else begin
         img_rd     <= image_mem[addr_c];
         idx_q      <= img_rd;
         idx_d      <= idx_q;
         pal_rd     <= palette_mem[idx_q];
         in_s1      <= in_sprite_c;
         in_s2      <= in_s1;
         in_s3      <= in_s2;
         opaque_out <= opaque_c;
         red_out    <= opaque_c ? pal_rd[23:16] : 8'd0;
         green_out  <= opaque_c ? pal_rd[15:8]  : 8'd0;
         blue_out   <= opaque_c ? pal_rd[7:0]   : 8'd0;
      end
   end

   assign frame_idx_out = frame_q;

endmodule

// File: tb/tb_animated_sprite.sv
// Scoreboard bench for animated_sprite: the driver pushes expected pixels/frame indices,
// a negedge monitor pops and compares them when they fall due.
module tb_animated_sprite;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [10:0] x_in, hcount;
   logic [9:0]  y_in, vcount;
   logic        new_frame, anim_en;
`ifdef SPRITE_HFLIP_EN
   logic        hflip;
`endif
   logic [7:0]  red, green, blue;
   logic        opaque;
   logic [1:0]  frame_idx;

   always #5 clk = ~clk;

   animated_sprite #(.IMAGE_FILE(""), .PALETTE_FILE("")) dut (
      .pixel_clk_in (clk),
      .rst_n_in     (rst_n),
      .x_in         (x_in),
      .y_in         (y_in),
      .hcount_in    (hcount),
      .vcount_in    (vcount),
      .new_frame_in (new_frame),
      .anim_en_in   (anim_en),
`ifdef SPRITE_HFLIP_EN
      .hflip_in     (hflip),
`endif
      .red_out      (red),
      .green_out    (green),
      .blue_out     (blue),
      .opaque_out   (opaque),
      .frame_idx_out(frame_idx)
   );

   typedef struct { int due; logic [24:0] pix; } pix_t;
   typedef struct { int due; logic [1:0]  fr;  } fr_t;
   pix_t pq[$];
   fr_t  fq[$];

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   logic [7:0]  img [16384];
   logic [23:0] pal [256];

   // Reference state of the sprite as the spec describes it.
   int mx = 0, my = 0, mhold = 0, mframe = 0;
   bit mflip = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [24:0] exp_pix(int h, int v);
      int dx, dy;
      logic [7:0] idx;
      if (h < mx || h >= mx + 128 || v < my || v >= my + 128) return 25'd0;
      dx = (h - mx) / 2;
      dy = (v - my) / 2;
      if (mflip) dx = 63 - dx;
      idx = img[mframe * 4096 + dy * 64 + dx];
      if (idx == 8'd0) return 25'd0;
      return {1'b1, pal[idx]};
   endfunction

   task automatic drive(int h, int v, bit nf, bit rst);
      @(posedge clk);
      #1;
      hcount    = 11'(h);
      vcount    = 10'(v);
      new_frame = nf;
      rst_n     = ~rst;
      if (rst) begin
         foreach (pq[i]) if (pq[i].due > cyc) pq[i].pix = 25'd0;
         pq.push_back('{cyc + 4, 25'd0});
         mx = 0; my = 0; mhold = 0; mframe = 0; mflip = 1'b0;
      end else begin
         pq.push_back('{cyc + 4, exp_pix(h, v)});
         if (nf) begin
            mx = int'(x_in);
            my = int'(y_in);
`ifdef SPRITE_HFLIP_EN
            mflip = hflip;
`endif
            if (anim_en) begin
               if (mhold == 7) begin
                  mhold  = 0;
                  mframe = (mframe + 1) % 4;
               end else begin
                  mhold = mhold + 1;
               end
            end
         end
      end
      fq.push_back('{cyc + 1, 2'(mframe)});
   endtask

   task automatic sweep(int h0, int h1, int v);
      for (int h = h0; h <= h1; h++) drive(h, v, 1'b0, 1'b0);
   endtask

   task automatic pulses(int n);
      for (int i = 0; i < n; i++) drive(0, 0, 1'b1, 1'b0);
   endtask

   // Monitor: compare every output that is due this cycle.
   always @(negedge clk) begin
      pix_t e;
      fr_t  f;
      while (pq.size() > 0 && pq[0].due <= cyc) begin
         e = pq.pop_front();
         total++;
         if (e.due != cyc || {opaque, red, green, blue} !== e.pix) begin
            bad++;
            $display("FAIL pixel cyc=%0d due=%0d: got opaque=%b rgb=%h, expected opaque=%b rgb=%h",
                     cyc, e.due, opaque, {red, green, blue}, e.pix[24], e.pix[23:0]);
         end
      end
      while (fq.size() > 0 && fq[0].due <= cyc) begin
         f = fq.pop_front();
         total++;
         if (f.due != cyc || frame_idx !== f.fr) begin
            bad++;
            $display("FAIL frame_idx cyc=%0d: got %0d expected %0d", cyc, frame_idx, f.fr);
         end
      end
   end

   initial begin
      for (int i = 0; i < 16384; i++) img[i] = 8'((i * 37 + 11) % 256);
      img[0] = 8'd5;
      img[1] = 8'd9;
      img[2] = 8'd0;
      img[4096] = 8'd77;
      for (int i = 0; i < 256; i++) pal[i] = {8'(i), 8'(255 - i), 8'(i * 3)};
      pal[0] = 24'hABCDEF;
      for (int i = 0; i < 16384; i++) dut.image_mem[i] = img[i];
      for (int i = 0; i < 256; i++) dut.palette_mem[i] = pal[i];

      x_in = 11'd100; y_in = 10'd50; anim_en = 1'b0;
      hcount = '0; vcount = '0; new_frame = 1'b0; rst_n = 1'b0;
`ifdef SPRITE_HFLIP_EN
      hflip = 1'b0;
`endif
      drive(0, 0, 1'b0, 1'b1);
      drive(0, 0, 1'b0, 1'b1);
      drive(0, 0, 1'b1, 1'b0);

      // Full row sweep across both horizontal edges, plus vertical edges.
      sweep(96, 231, 50);
      sweep(99, 104, 49);
      sweep(99, 104, 177);
      sweep(99, 104, 178);

      // Position change without a pulse must not take effect.
      x_in = 11'd300;
      sweep(98, 105, 60);
      sweep(298, 305, 60);
      drive(0, 0, 1'b1, 1'b0);
      sweep(298, 305, 60);
      sweep(98, 105, 60);

      // Right-edge sprite must not wrap into low columns.
      x_in = 11'd1980;
      drive(0, 0, 1'b1, 1'b0);
      sweep(1976, 2047, 50);
      sweep(0, 110, 50);

      // Animation: advance, wrap, freeze, resume.
      x_in = 11'd100;
      anim_en = 1'b1;
      pulses(8);
      sweep(100, 103, 50);
      pulses(24);
      pulses(3);
      anim_en = 1'b0;
      pulses(5);
      anim_en = 1'b1;
      pulses(5);
      sweep(100, 103, 50);

      // Reset while drawing, then reset colliding with a frame pulse.
      anim_en = 1'b0;
      sweep(100, 110, 52);
      drive(111, 52, 1'b0, 1'b1);
      sweep(200, 210, 52);
      drive(0, 0, 1'b1, 1'b0);
      sweep(100, 104, 50);
      drive(0, 0, 1'b1, 1'b1);
      sweep(0, 5, 4);
      sweep(126, 129, 4);

`ifdef SPRITE_HFLIP_EN
      hflip = 1'b1;
      drive(0, 0, 1'b1, 1'b0);
      sweep(98, 105, 50);
      sweep(222, 229, 50);
      hflip = 1'b0;
      drive(0, 0, 1'b1, 1'b0);
      sweep(98, 101, 50);
`endif

      sweep(0, 5, 700);
      for (int i = 0; i < 20 && (pq.size() > 0 || fq.size() > 0); i++) @(posedge clk);
      if (pq.size() > 0 || fq.size() > 0) begin
         total++;
         bad++;
         $display("FAIL drain: %0d pixel and %0d frame entries left, expected 0", pq.size(), fq.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
